// File: rtl/sha3_pad_streamer.sv
// SHA-3 absorb front end: forwards message bytes to the sponge controller and
// appends domain/zero/0x80 padding so the controller only ever sees whole rate blocks.
module sha3_pad_streamer #(
    parameter int          RATE_BYTES  = 136,
    parameter logic [7:0]  DOMAIN_BYTE = 8'h06
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       go_empty,
    input  logic [7:0] msg_data,
    input  logic       msg_valid,
    input  logic       msg_last,
    output logic       msg_ready,
    input  logic       absorb_ready,
    output logic       start,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       last_block,
    output logic       busy,
    output logic       pad_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PASS,
        S_PAD,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(RATE_BYTES - 1);

    state_t     state_q, state_d;
    logic [7:0] byte_idx_q, byte_idx_d;
    logic       empty_q, empty_d;
    logic       first_q, first_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       last_block_q, last_block_d;

    logic       can_issue;
    logic       at_last;
    logic [7:0] idx_inc;

    // One byte every other cycle at most: the previous strobe blocks the next issue.
    assign can_issue = absorb_ready && !data_valid_q;
    assign at_last   = (byte_idx_q == LAST_IDX);
    assign idx_inc   = at_last ? 8'd0 : byte_idx_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        empty_d      = empty_q;
        first_d      = first_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        last_block_d = 1'b0;
        msg_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    empty_d = go_empty;
                    state_d = S_START;
                end
            end
            S_START: begin
                byte_idx_d = 8'd0;
                first_d    = 1'b1;
                state_d    = empty_q ? S_PAD : S_PASS;
            end
            S_PASS: begin
                msg_ready = can_issue;
                if (msg_valid && can_issue) begin
                    data_out_d   = msg_data;
                    data_valid_d = 1'b1;
                    byte_idx_d   = idx_inc;
                    if (msg_last) begin
                        first_d = 1'b1;
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                last_block_d = 1'b1;
                if (can_issue) begin
                    // A lone pad byte carries both the domain suffix and the final bit.
                    if (at_last) begin
                        data_out_d = first_q ? (DOMAIN_BYTE | 8'h80) : 8'h80;
                        state_d    = S_DONE;
                    end else begin
                        data_out_d = first_q ? DOMAIN_BYTE : 8'h00;
                    end
                    data_valid_d = 1'b1;
                    first_d      = 1'b0;
                    byte_idx_d   = idx_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 8'd0;
            empty_q      <= 1'b0;
            first_q      <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            last_block_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            empty_q      <= empty_d;
            first_q      <= first_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            last_block_q <= last_block_d;
        end
    end

    assign start      = (state_q == S_START);
    assign busy       = (state_q != S_IDLE);
    assign pad_done   = (state_q == S_DONE);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign last_block = last_block_q;

endmodule

// File: doc/sha3_pad_streamer.md
Name: sha3_pad_streamer

Overview:
- Host-side absorb front end for the SHA-3-256 core.
- Accepts a raw message byte stream over valid/ready and applies SHA-3 padding: domain byte 0x06, zero fill, final 0x80 (0x86 when the first and final pad bytes coincide).
- Drives the controller's start, data, data_valid and last_block pins, paced by absorb_ready.
- Sits directly upstream of the controller and absorbs whole rate blocks only.

Parameters:
- RATE_BYTES, 136, sponge rate in bytes (SHA3-256).
- DOMAIN_BYTE, 8'h06, first pad byte (SHA-3 domain suffix).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- go  in  1  begin a new hash; honoured in IDLE only.
- go_empty  in  1  sampled with go; 1 means zero-length message.
- msg_data  in  8  message byte.
- msg_valid  in  1  msg_data valid.
- msg_last  in  1  qualifies msg_data as the final message byte.
- msg_ready  out  1  byte accepted when msg_valid && msg_ready.
- absorb_ready  in  1  controller can take a byte.
- start  out  1  one-cycle start pulse to controller.
- data_out  out  8  byte to controller.
- data_valid  out  1  one-cycle byte strobe to controller.
- last_block  out  1  current block is the final padded block.
- busy  out  1  state != IDLE.
- pad_done  out  1  one-cycle pulse after the final pad byte is issued.

Behaviour:
- Reset: state=IDLE, byte_idx=0. start, data_valid, last_block, pad_done, msg_ready and busy are 0; data_out=0x00. Reset takes effect immediately in any state and abandons the hash; nothing resumes after reset.
- States: IDLE, START, PASS, PAD, DONE.
- IDLE -> START on go. go_empty is latched at this point. go outside IDLE is ignored.
- START: start=1 for exactly this cycle, byte_idx cleared. Next state is PAD if go_empty was latched, else PASS.
- Output pacing:
  - A byte is issued only when absorb_ready=1 and data_valid was 0 in the previous cycle. Minimum spacing is 2 cycles per byte.
  - data_out, data_valid and last_block are registered. A byte accepted or generated in cycle N appears with data_valid=1 in cycle N+1.
- PASS:
  - msg_ready = absorb_ready && !data_valid; 0 in every other state.
  - Accepted byte is forwarded unchanged with last_block=0; byte_idx increments.
  - Accepted byte with msg_last=1 -> PAD. If that byte filled the block (idx wrapped to 0), PAD produces a complete extra block.
- PAD:
  - Generates bytes at byte_idx with last_block=1 on every PAD byte.
  - First pad byte = DOMAIN_BYTE, OR 0x80 if byte_idx==RATE_BYTES-1.
  - Middle pad bytes = 0x00.
  - Byte at RATE_BYTES-1 = 0x80.
  - After the RATE_BYTES-1 byte is issued -> DONE.
- DONE: pad_done=1 for one cycle, then -> IDLE.
- byte_idx:
  - 8-bit counter, 0..RATE_BYTES-1.
  - Increments on every issued byte; wraps to 0 after RATE_BYTES-1.
  - Every block is exactly RATE_BYTES data_valid strobes.
- absorb_ready low stalls issue indefinitely, with no loss or duplication. In PASS, msg_ready stays 0 while stalled.
- msg_valid outside PASS is ignored.
- msg_last without msg_valid has no effect.

Test Plan:
- go=1, go_empty=1 -> start pulse, then 136 strobes: 0x06, 134×0x00, 0x80, all with last_block=1; pad_done once; busy falls after DONE.
- "abc" (61 62 63, last on 63) -> 61 62 63 (last_block=0), then 06, 131×00, 80 (last_block=1); 136 strobes total.
- 135-byte message -> 135 bytes with last_block=0, then a single 0x86 with last_block=1; pad_done follows.
- 136-byte message -> 136 bytes with last_block=0, then a full block 06, 134×00, 80 with last_block=1; 272 strobes total.
- absorb_ready held low 10 cycles mid-PASS and mid-PAD -> no data_valid, msg_ready=0 throughout; the output sequence is identical to the unstalled run, and strobes are never closer than 2 cycles.
- rst asserted mid-PAD -> all outputs 0 in the same cycle; a subsequent go plus a 3-byte message yields the correct single padded block.
